regfile_march_bist: RTL and testbench

- Built-in self-test controller for the 32x32 integer register file in the decode stage.
- On request, takes ownership of one write port (WE3/A3/WD3) and one read port (A1/RD1) through an external mux selected by bist_en.
- Runs a March C- sequence over x1..x31 and reports pass/fail with first-failure diagnostics.
- Sits beside the decode stage. The pipeline is held off by the top level while bist_busy=1.

---
 rtl/regfile_march_bist.sv | 141 ++++++++++++++
 tb/tb_regfile_march_bist.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_march_bist.sv
// rtl/regfile_march_bist.sv - March C- self-test controller for the 32x32 decode-stage register file
module regfile_march_bist #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter int                FIRST_ADDR = 1,
    parameter int                LAST_ADDR  = 31,
    parameter logic [DATA_W-1:0] PATTERN    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bist_start,
    input  logic              bist_abort,
    output logic              bist_en,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic [ADDR_W-1:0] rf_ra,
    input  logic [DATA_W-1:0] rf_rd,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_pass,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [DATA_W-1:0] fail_data,
    output logic [7:0]        err_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, wa_hold, ra_hold;
    logic [2:0]        elem;
    logic              phase;     // 1 = write half of a read-write pair
    logic              pass_q;
    logic              op_rd, op_wr, desc, last_addr, step, miscmp;
    logic [DATA_W-1:0] rd_exp, wr_dat;

    always_comb begin
        state_nxt = state;
        op_wr     = 1'b0;
        op_rd     = 1'b0;
        desc      = (elem == 3'd3) || (elem == 3'd4);
        rd_exp    = ((elem == 3'd2) || (elem == 3'd4)) ? ~PATTERN : PATTERN;
        wr_dat    = ((elem == 3'd1) || (elem == 3'd3)) ? ~PATTERN : PATTERN;
        last_addr = desc ? (addr == FIRST_A) : (addr == LAST_A);
        if (state == RUN) begin
            // E0 is write-only, E5 read-only, E1..E4 alternate read then write
            op_wr = (elem == 3'd0) || ((elem != 3'd5) && phase);
            op_rd = !op_wr;
        end
        step   = op_wr || (op_rd && (elem == 3'd5));
        miscmp = op_rd && (rf_rd != rd_exp);
        case (state)
            IDLE: if (bist_start && !bist_abort) state_nxt = RUN;
            RUN: begin
                if (bist_abort)
                    state_nxt = IDLE;
                else if (step && last_addr && (elem == 3'd5))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bist_en   = (state == RUN);
    assign bist_busy = (state == RUN);
    assign bist_done = (state == DONE);
    assign bist_pass = (state == DONE) ? ~bist_fail : pass_q;
    assign rf_we     = op_wr;
    assign rf_wa     = op_wr ? addr : wa_hold;
    assign rf_ra     = op_rd ? addr : ra_hold;
    assign rf_wd     = op_wr ? wr_dat : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            elem      <= '0;
            phase     <= 1'b0;
            wa_hold   <= '0;
            ra_hold   <= '0;
            pass_q    <= 1'b0;
            bist_fail <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_data <= '0;
            err_count <= '0;
        end else begin
            state <= state_nxt;
            if (op_wr) wa_hold <= addr;
            if (op_rd) ra_hold <= addr;
            case (state)
                IDLE: begin
                    if (state_nxt == RUN) begin
                        addr      <= FIRST_A;
                        elem      <= '0;
                        phase     <= 1'b0;
                        pass_q    <= 1'b0;
                        bist_fail <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= '0;
                        fail_data <= '0;
                        err_count <= '0;
                    end
                end
                RUN: begin
                    if (miscmp) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        if (!bist_fail) begin
                            bist_fail <= 1'b1;
                            fail_addr <= addr;
                            fail_elem <= elem;
                            fail_data <= rf_rd;
                        end
                    end
                    if (bist_abort) begin
                        pass_q <= 1'b0;
                    end else if (op_rd && (elem != 3'd5)) begin
                        phase <= 1'b1;
                    end else if (step) begin
                        phase <= 1'b0;
                        if (!last_addr)
                            addr <= desc ? addr - ONE_A : addr + ONE_A;
                        else if (elem != 3'd5) begin
                            // E3 and E4 run descending, so they start from the top
                            elem <= elem + 3'd1;
                            addr <= ((elem == 3'd2) || (elem == 3'd3)) ? LAST_A : FIRST_A;
                        end
                    end
                end
                DONE:    pass_q <= ~bist_fail;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_march_bist.sv
// tb/tb_regfile_march_bist.sv - self-checking bench for regfile_march_bist with faulty register-file model
module tb_regfile_march_bist;
    localparam logic [31:0] P2 = 32'hA5A5A5A5;

    logic clk = 1'b0;
    logic rst, bist_start, bist_abort;
    always #5 clk = ~clk;

    logic        en1, we1, busy1, done1, pass1, fail1;
    logic [4:0]  wa1, ra1, fa1;
    logic [31:0] wd1, rd1, fd1;
    logic [2:0]  fe1;
    logic [7:0]  ec1;
    logic        en2, we2, busy2, done2, pass2, fail2;
    logic [4:0]  wa2, ra2, fa2;
    logic [31:0] wd2, rd2, fd2;
    logic [2:0]  fe2;
    logic [7:0]  ec2;

    regfile_march_bist u_dut (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
        .bist_en(en1), .rf_we(we1), .rf_wa(wa1), .rf_wd(wd1), .rf_ra(ra1), .rf_rd(rd1),
        .bist_busy(busy1), .bist_done(done1), .bist_pass(pass1), .bist_fail(fail1),
        .fail_addr(fa1), .fail_elem(fe1), .fail_data(fd1), .err_count(ec1)
    );

    regfile_march_bist #(.PATTERN(P2)) u_dut_a5 (
        .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
        .bist_en(en2), .rf_we(we2), .rf_wa(wa2), .rf_wd(wd2), .rf_ra(ra2), .rf_rd(rd2),
        .bist_busy(busy2), .bist_done(done2), .bist_pass(pass2), .bist_fail(fail2),
        .fail_addr(fa2), .fail_elem(fe2), .fail_data(fd2), .err_count(ec2)
    );

    // Register files: write on edge, combinational read, stuck-at masks applied on read
    logic [31:0] mem1 [32];
    logic [31:0] mem2 [32];
    logic [31:0] sa1 [32];
    logic [31:0] sa0 [32];
    always @(posedge clk) begin
        if (we1) mem1[wa1] <= wd1;
        if (we2) mem2[wa2] <= wd2;
    end
    assign rd1 = (mem1[ra1] | sa1[ra1]) & ~sa0[ra1];
    assign rd2 = mem2[ra2];

    typedef struct packed { bit we; bit [4:0] a; bit [31:0] d; } op_t;
    op_t q1[$];
    op_t q2[$];
    op_t o1, o2;

    int          checks = 0, errors = 0;
    int          tr_err1, tr_err2, busy_cnt, done_cnt;
    bit          exp_fail;
    bit [4:0]    exp_fa;
    bit [2:0]    exp_fe;
    bit [31:0]   exp_fd;
    int          exp_cnt;

    // Reference: expand March C- element list into an op list and simulate faults on it
    function automatic void build(input int which);
        bit [31:0] pat, bg, act;
        bit [31:0] m [32];
        int a;
        pat = (which == 1) ? 32'h0 : P2;
        if (which == 1) begin
            exp_fail = 0; exp_fa = 0; exp_fe = 0; exp_fd = 0; exp_cnt = 0;
        end
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 31; k++) begin
                a = (e == 3 || e == 4) ? 31 - k : 1 + k;
                if (e != 0) begin
                    bg = (e == 2 || e == 4) ? ~pat : pat;
                    if (which == 1) begin
                        q1.push_back('{1'b0, a[4:0], bg});
                        act = (m[a] | sa1[a]) & ~sa0[a];
                        if (act != bg) begin
                            if (!exp_fail) begin
                                exp_fail = 1; exp_fa = a[4:0]; exp_fe = e[2:0]; exp_fd = act;
                            end
                            if (exp_cnt < 255) exp_cnt++;
                        end
                    end else
                        q2.push_back('{1'b0, a[4:0], bg});
                end
                if (e <= 4) begin
                    bg = (e == 1 || e == 3) ? ~pat : pat;
                    if (which == 1) q1.push_back('{1'b1, a[4:0], bg});
                    else            q2.push_back('{1'b1, a[4:0], bg});
                    m[a] = bg;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (busy1) busy_cnt++;
        if (done1) done_cnt++;
        if (!en1 && we1) tr_err1++;
        if (!en2 && we2) tr_err2++;
        if (en1) begin
            if (q1.size() == 0) tr_err1++;
            else begin
                o1 = q1.pop_front();
                if (we1 !== o1.we || (o1.we ? (wa1 !== o1.a || wd1 !== o1.d) : (ra1 !== o1.a))) tr_err1++;
            end
        end
        if (en2) begin
            if (q2.size() == 0) tr_err2++;
            else begin
                o2 = q2.pop_front();
                if (we2 !== o2.we || (o2.we ? (wa2 !== o2.a || wd2 !== o2.d) : (ra2 !== o2.a))) tr_err2++;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_faults(input logic [4:0] fa, input logic [31:0] m1, input logic [4:0] fb, input logic [31:0] m0);
        for (int i = 0; i < 32; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
        sa1[fa] = sa1[fa] | m1;
        sa0[fb] = sa0[fb] | m0;
    endtask

    task automatic prepare();
        q1.delete(); q2.delete();
        build(1); build(2);
        tr_err1 = 0; tr_err2 = 0; busy_cnt = 0; done_cnt = 0;
    endtask

    task automatic start_pulse();
        @(negedge clk); bist_start = 1'b1;
        @(negedge clk); bist_start = 1'b0;
    endtask

    task automatic run_march(input string tag, input int repulse);
        int lat;
        lat = -1;
        prepare();
        start_pulse();
        for (int i = 0; i < 400; i++) begin
            bist_start = (i == repulse);
            if (done1) begin
                lat = i;
                chk({tag, ".pass_in_done"}, pass1, !exp_fail);
                break;
            end
            @(negedge clk);
        end
        bist_start = 1'b0;
        chk({tag, ".done_seen"}, lat >= 0, 1'b1);
        chk({tag, ".done_cycle"}, lat, 310);
        @(negedge clk);
        chk({tag, ".busy_cycles"}, busy_cnt, 310);
        chk({tag, ".done_pulses"}, done_cnt, 1);
        chk({tag, ".trace"}, tr_err1, 0);
        chk({tag, ".trace_a5"}, tr_err2, 0);
        chk({tag, ".pass_a5"}, pass2, 1'b1);
        chk({tag, ".idle"}, {en1, busy1, done1}, 3'b000);
    endtask

    task automatic check_result(input string tag, input bit e_pass, input logic [4:0] e_addr,
                                input logic [2:0] e_elem, input logic [31:0] e_data, input logic [7:0] e_cnt);
        chk({tag, ".pass"}, pass1, e_pass);
        chk({tag, ".fail"}, fail1, !e_pass);
        chk({tag, ".fail_addr"}, fa1, e_addr);
        chk({tag, ".fail_elem"}, fe1, e_elem);
        chk({tag, ".fail_data"}, fd1, e_data);
        chk({tag, ".err_count"}, ec1, e_cnt);
    endtask

    typedef struct {
        logic [4:0] fa; logic [31:0] m1; logic [4:0] fb; logic [31:0] m0;
        bit e_pass; logic [4:0] e_addr; logic [2:0] e_elem; logic [31:0] e_data; logic [7:0] e_cnt;
    } vec_t;
    vec_t tbl[5];

    initial begin
        tbl[0] = '{5'd0,  32'h0,        5'd0,  32'h0,        1'b1, 5'd0,  3'd0, 32'h0,        8'd0};
        tbl[1] = '{5'd5,  32'h1,        5'd0,  32'h0,        1'b0, 5'd5,  3'd1, 32'h1,        8'd3};
        tbl[2] = '{5'd0,  32'h0,        5'd31, 32'h80000000, 1'b0, 5'd31, 3'd2, 32'h7FFFFFFF, 8'd2};
        tbl[3] = '{5'd1,  32'hFFFFFFFF, 5'd0,  32'h0,        1'b0, 5'd1,  3'd1, 32'hFFFFFFFF, 8'd3};
        tbl[4] = '{5'd3,  32'h10,       5'd7,  32'h1,        1'b0, 5'd3,  3'd1, 32'h10,       8'd5};

        rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0;
        tr_err1 = 0; tr_err2 = 0; busy_cnt = 0; done_cnt = 0;
        set_faults(5'd0, 32'h0, 5'd0, 32'h0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", {en1, we1, wa1, wd1, ra1, busy1, done1, pass1, fail1, fa1, fe1, fd1, ec1}, '0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            set_faults(tbl[t].fa, tbl[t].m1, tbl[t].fb, tbl[t].m0);
            run_march($sformatf("tbl%0d", t), -1);
            check_result($sformatf("tbl%0d", t), tbl[t].e_pass, tbl[t].e_addr,
                         tbl[t].e_elem, tbl[t].e_data, tbl[t].e_cnt);
        end

        for (int t = 0; t < 6; t++) begin
            set_faults(5'($urandom_range(31, 1)), 32'h1 << $urandom_range(31, 0),
                       5'($urandom_range(31, 1)), $urandom & $urandom);
            run_march($sformatf("rnd%0d", t), -1);
            check_result($sformatf("rnd%0d", t), !exp_fail, exp_fa, exp_fe, exp_fd, 8'(exp_cnt));
        end

        // Start re-pulsed mid-run is ignored; done still lands 311 cycles after the original start
        set_faults(5'd0, 32'h0, 5'd0, 32'h0);
        run_march("repulse", 49);

        // Abort at RUN cycle 100 with a stuck bit already hit in E1
        set_faults(5'd5, 32'h1, 5'd0, 32'h0);
        prepare();
        start_pulse();
        repeat (99) @(negedge clk);
        bist_abort = 1'b1;
        @(negedge clk);
        bist_abort = 1'b0;
        chk("abort.outputs", {busy1, en1, we1, done1, pass1}, 5'b00000);
        chk("abort.retained", {fail1, fa1, fe1, fd1, ec1}, {1'b1, 5'd5, 3'd1, 32'h1, 8'd1});
        chk("abort.trace", tr_err1, 0);
        repeat (5) @(negedge clk);
        chk("abort.no_done", done_cnt, 0);
        set_faults(5'd0, 32'h0, 5'd0, 32'h0);
        run_march("after_abort", -1);
        check_result("after_abort", 1'b1, 5'd0, 3'd0, 32'h0, 8'd0);

        // Reset at RUN cycle 200 after an injected error
        set_faults(5'd5, 32'h1, 5'd0, 32'h0);
        prepare();
        start_pulse();
        repeat (199) @(negedge clk);
        chk("pre_reset.fail", {fail1, ec1}, {1'b1, 8'd1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_reset_outputs", {en1, we1, wa1, wd1, ra1, busy1, done1, pass1, fail1, fa1, fe1, fd1, ec1}, '0);

        // Start together with abort in IDLE stays in IDLE
        @(negedge clk);
        bist_start = 1'b1; bist_abort = 1'b1;
        @(negedge clk);
        bist_start = 1'b0; bist_abort = 1'b0;
        chk("start_abort.idle", {en1, busy1, we1}, 3'b000);
        @(negedge clk);
        chk("start_abort.still_idle", {en1, busy1, done1}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
